mole_hit_detector: RTL and testbench

- Consumer end of the mole interface: reads the one-hot `mole_position` driven by the mole generator and the five raw player buttons.
- Per mole window, decides hit / miss / wrong-press and keeps the score and miss count.
- Raises `game_over` after too many misses.
- Drives `mole_mask` to the LEDs, so a whacked mole goes dark immediately.
- Sits between the board buttons, the mole generator and the score display / game-control FSM.

---
 rtl/mole_hit_detector.sv | 141 ++++++++++++++
 tb/tb_mole_hit_detector.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mole_hit_detector.sv
// Whack-a-mole hit detector: debounces the player buttons, scores each mole window
// as hit / miss / wrong press, and tracks score, misses and game over.
module mole_hit_detector #(
  parameter int NUM_MOLES       = 5,
  parameter int SCORE_WIDTH     = 8,
  parameter int MISS_WIDTH      = 4,
  parameter int MAX_MISSES      = 3,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   pulse,
  input  logic [NUM_MOLES-1:0]   mole_position,
  input  logic [NUM_MOLES-1:0]   buttons,
  output logic [NUM_MOLES-1:0]   mole_mask,
  output logic [SCORE_WIDTH-1:0] score,
  output logic [MISS_WIDTH-1:0]  misses,
  output logic                   hit_pulse,
  output logic                   miss_pulse,
  output logic                   game_over
);

  localparam int                    CNT_W      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [MISS_WIDTH-1:0] MISS_LIMIT = MISS_WIDTH'(MAX_MISSES);

  typedef enum logic [1:0] {IDLE, ARMED, CLOSED, OVER} state_e;

  function automatic logic [SCORE_WIDTH-1:0] sat_inc(input logic [SCORE_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [NUM_MOLES-1:0]            sync1_q, sync2_q, deb_q, deb_prev_q;
  logic [NUM_MOLES-1:0][CNT_W-1:0] cnt_q;
  logic [NUM_MOLES-1:0]            press_d;

  state_e                  state_q;
  logic [NUM_MOLES-1:0]    cur_mole_q;
  logic [SCORE_WIDTH-1:0]  score_q, score_inc_d;
  logic [MISS_WIDTH-1:0]   misses_q, misses_inc_d;
  logic                    hit_q, miss_q, game_over_q, enable_q, pulse_d_q;

  // A level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      cnt_q      <= '0;
    end else begin
      sync1_q    <= buttons;
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_q;
      for (int i = 0; i < NUM_MOLES; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          deb_q[i] <= sync2_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign press_d      = deb_q & ~deb_prev_q;
  assign score_inc_d  = sat_inc(score_q);
  assign misses_inc_d = misses_q + 1'b1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cur_mole_q  <= '0;
      score_q     <= '0;
      misses_q    <= '0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
      game_over_q <= 1'b0;
      enable_q    <= 1'b0;
      pulse_d_q   <= 1'b0;
    end else begin
      enable_q  <= enable;
      pulse_d_q <= pulse;
      hit_q     <= 1'b0;
      miss_q    <= 1'b0;
      if (!enable) begin
        state_q    <= IDLE;
        cur_mole_q <= '0;
      end else if (!enable_q) begin
        state_q     <= IDLE;
        cur_mole_q  <= '0;
        score_q     <= '0;
        misses_q    <= '0;
        game_over_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE, CLOSED: begin
            if (pulse) begin
              state_q <= CLOSED;
            end else if (pulse_d_q) begin
              cur_mole_q <= mole_position;
              state_q    <= (|mole_position) ? ARMED : CLOSED;
            end
          end
          ARMED: begin
            // An expiring window outranks a simultaneous press.
            if (pulse || (|press_d)) begin
              if (!pulse && (press_d == cur_mole_q)) begin
                score_q <= score_inc_d;
                hit_q   <= 1'b1;
                state_q <= CLOSED;
              end else begin
                misses_q <= misses_inc_d;
                miss_q   <= 1'b1;
                if (misses_inc_d == MISS_LIMIT) begin
                  game_over_q <= 1'b1;
                  state_q     <= OVER;
                end else begin
                  state_q <= CLOSED;
                end
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign mole_mask  = (enable && (state_q == ARMED)) ? cur_mole_q : '0;
  assign score      = score_q;
  assign misses     = misses_q;
  assign hit_pulse  = hit_q;
  assign miss_pulse = miss_q;
  assign game_over  = game_over_q;

endmodule

// File: tb/tb_mole_hit_detector.sv
// Bench for mole_hit_detector: directed game scenarios plus random play,
// every cycle compared against a rule-level model of the game.
module tb_mole_hit_detector;
  localparam int N    = 5;
  localparam int SW   = 8;
  localparam int MW   = 4;
  localparam int MAXM = 3;
  localparam int DB   = 4;

  logic          clock = 1'b0;
  logic          reset, enable, pulse;
  logic [N-1:0]  mole_position, buttons, mole_mask;
  logic [SW-1:0] score;
  logic [MW-1:0] misses;
  logic          hit_pulse, miss_pulse, game_over;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  mole_hit_detector #(
    .NUM_MOLES(N), .SCORE_WIDTH(SW), .MISS_WIDTH(MW),
    .MAX_MISSES(MAXM), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .pulse(pulse),
    .mole_position(mole_position), .buttons(buttons), .mole_mask(mole_mask),
    .score(score), .misses(misses), .hit_pulse(hit_pulse),
    .miss_pulse(miss_pulse), .game_over(game_over)
  );

  // Game model: window armed/closed, target mole, plain integer counters.
  int           m_score, m_misses;
  bit           m_armed, m_over, m_go, m_hit, m_miss, m_en_prev, m_pulse_prev;
  logic [N-1:0] m_target, m_deb, m_deb_prev;
  logic [N-1:0] rawq[$];
  logic         last_hit;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_miss();
    m_misses++;
    m_miss  = 1'b1;
    m_armed = 1'b0;
    if (m_misses == MAXM) begin
      m_go   = 1'b1;
      m_over = 1'b1;
    end
  endtask

  task automatic model_step();
    logic [N-1:0] press, s;
    bit flip;
    if (!reset) begin
      m_score = 0; m_misses = 0;
      m_armed = 0; m_over = 0; m_go = 0; m_hit = 0; m_miss = 0;
      m_en_prev = 0; m_pulse_prev = 0;
      m_target = '0; m_deb = '0; m_deb_prev = '0;
      rawq.delete();
      repeat (DB + 2) rawq.push_back('0);
      return;
    end
    press = m_deb & ~m_deb_prev;
    m_hit = 0;
    m_miss = 0;
    if (!enable) begin
      m_armed = 0;
      m_over  = 0;
    end else if (!m_en_prev) begin
      m_score = 0; m_misses = 0; m_go = 0; m_armed = 0; m_over = 0;
    end else if (!m_over) begin
      if (m_armed) begin
        if (pulse) model_miss();
        else if (press == m_target) begin
          if (m_score < (1 << SW) - 1) m_score++;
          m_hit   = 1'b1;
          m_armed = 1'b0;
        end else if (press != '0) model_miss();
      end else if (!pulse && m_pulse_prev) begin
        m_target = mole_position;
        m_armed  = (mole_position != '0);
      end
    end
    m_en_prev    = enable;
    m_pulse_prev = pulse;
    m_deb_prev   = m_deb;
    // Accepted level flips once the DB synchronized samples (two edges old) all disagree.
    rawq.push_back(buttons);
    for (int b = 0; b < N; b++) begin
      flip = 1'b1;
      for (int j = 2; j <= DB + 1; j++) begin
        s = rawq[rawq.size() - 1 - j];
        if (s[b] == m_deb[b]) flip = 1'b0;
      end
      if (flip) m_deb[b] = ~m_deb[b];
    end
    while (rawq.size() > DB + 3) void'(rawq.pop_front());
  endtask

  task automatic tick();
    logic [N-1:0] em;
    @(posedge clock);
    model_step();
    @(negedge clock);
    em = (m_armed && enable) ? m_target : '0;
    check_eq("mask", 32'(mole_mask), 32'(em));
    check_eq("score", 32'(score), m_score);
    check_eq("misses", 32'(misses), m_misses);
    check_eq("hit_pulse", 32'(hit_pulse), 32'(m_hit));
    check_eq("miss_pulse", 32'(miss_pulse), 32'(m_miss));
    check_eq("game_over", 32'(game_over), 32'(m_go));
  endtask

  task automatic do_pulse(input logic [N-1:0] m);
    pulse = 1'b1;
    tick();
    pulse = 1'b0;
    mole_position = m;
  endtask

  task automatic do_hit(input logic [N-1:0] m);
    do_pulse(m);
    tick();
    buttons = m;
    repeat (7) tick();
    last_hit = hit_pulse;
    repeat (2) tick();
    buttons = '0;
    repeat (7) tick();
  endtask

  initial begin
    logic [N-1:0] pick;
    reset = 1'b0; enable = 1'b0; pulse = 1'b0;
    mole_position = '0; buttons = '0; last_hit = 1'b0;
    repeat (3) tick();
    check_eq("reset_score", 32'(score), 0);
    check_eq("reset_go", 32'(game_over), 0);
    reset = 1'b1;
    repeat (2) tick();
    enable = 1'b1;
    tick();

    // Scenario 1: clean hit, latency, no repeat hit.
    do_pulse(5'b00100);
    tick();
    check_eq("t1_mask_armed", 32'(mole_mask), 32'h04);
    buttons = 5'b00100;
    repeat (6) tick();
    check_eq("t1_hit_early", 32'(hit_pulse), 0);
    check_eq("t1_mask_pre", 32'(mole_mask), 32'h04);
    tick();
    check_eq("t1_hit_edge7", 32'(hit_pulse), 1);
    check_eq("t1_score", 32'(score), 1);
    check_eq("t1_mask_dark", 32'(mole_mask), 0);
    repeat (3) tick();
    buttons = '0;
    repeat (8) tick();
    buttons = 5'b00100;
    repeat (10) tick();
    buttons = '0;
    repeat (8) tick();
    check_eq("t1_no_rehit", 32'(score), 1);

    // Scenario 2: window expires unhit.
    do_pulse(5'b00010);
    tick();
    check_eq("t2_mask", 32'(mole_mask), 32'h02);
    repeat (5) tick();
    do_pulse(5'b00001);
    check_eq("t2_miss_pulse", 32'(miss_pulse), 1);
    check_eq("t2_misses", 32'(misses), 1);
    check_eq("t2_score", 32'(score), 1);
    tick();

    // Scenario 3: wrong button, then correct button in same window.
    buttons = 5'b01000;
    repeat (7) tick();
    check_eq("t3_wrong_pulse", 32'(miss_pulse), 1);
    check_eq("t3_misses", 32'(misses), 2);
    repeat (3) tick();
    buttons = '0;
    repeat (8) tick();
    buttons = 5'b00001;
    repeat (10) tick();
    buttons = '0;
    repeat (8) tick();
    check_eq("t3_late_score", 32'(score), 1);
    check_eq("t3_late_misses", 32'(misses), 2);

    // Scenario 4: glitch ignored, two-button press is wrong.
    enable = 1'b0;
    tick();
    enable = 1'b1;
    tick();
    check_eq("t4_clr_score", 32'(score), 0);
    check_eq("t4_clr_misses", 32'(misses), 0);
    do_pulse(5'b00010);
    tick();
    buttons = 5'b00010;
    repeat (3) tick();
    buttons = '0;
    repeat (12) tick();
    check_eq("t4_glitch_misses", 32'(misses), 0);
    check_eq("t4_glitch_mask", 32'(mole_mask), 32'h02);
    buttons = 5'b00011;
    repeat (7) tick();
    check_eq("t4_multi_pulse", 32'(miss_pulse), 1);
    check_eq("t4_multi_misses", 32'(misses), 1);
    repeat (3) tick();
    buttons = '0;
    repeat (8) tick();

    // Scenario 5: game over and restart.
    do_pulse(5'b00001);
    tick();
    repeat (3) tick();
    do_pulse(5'b00100);
    check_eq("t5_misses2", 32'(misses), 2);
    tick();
    repeat (3) tick();
    do_pulse(5'b00010);
    check_eq("t5_go", 32'(game_over), 1);
    check_eq("t5_misses3", 32'(misses), 3);
    check_eq("t5_miss_pulse", 32'(miss_pulse), 1);
    tick();
    check_eq("t5_over_mask", 32'(mole_mask), 0);
    buttons = 5'b00010;
    repeat (10) tick();
    buttons = '0;
    repeat (8) tick();
    do_pulse(5'b00001);
    tick();
    check_eq("t5_over_score", 32'(score), 0);
    check_eq("t5_over_misses", 32'(misses), 3);
    check_eq("t5_over_mask2", 32'(mole_mask), 0);
    enable = 1'b0;
    tick();
    check_eq("t5_go_hold", 32'(game_over), 1);
    enable = 1'b1;
    tick();
    check_eq("t5_restart_go", 32'(game_over), 0);
    check_eq("t5_restart_misses", 32'(misses), 0);
    check_eq("t5_restart_score", 32'(score), 0);

    // Scenario 6: score saturation, then reset mid-window.
    for (int h = 0; h < 255; h++) do_hit(5'(1 << (h % N)));
    check_eq("t6_score255", 32'(score), 255);
    do_hit(5'b10000);
    check_eq("t6_sat_hit", 32'(last_hit), 1);
    check_eq("t6_sat_score", 32'(score), 255);
    do_pulse(5'b00100);
    tick();
    check_eq("t6_armed", 32'(mole_mask), 32'h04);
    reset = 1'b0;
    #1;
    check_eq("t6_rst_mask", 32'(mole_mask), 0);
    check_eq("t6_rst_score", 32'(score), 0);
    check_eq("t6_rst_misses", 32'(misses), 0);
    check_eq("t6_rst_hit", 32'(hit_pulse), 0);
    check_eq("t6_rst_miss", 32'(miss_pulse), 0);
    check_eq("t6_rst_go", 32'(game_over), 0);
    repeat (2) tick();
    reset = 1'b1;
    tick();

    // Random play.
    for (int c = 0; c < 3000; c++) begin
      if (pulse) begin
        pulse = 1'b0;
        pick = ($urandom_range(0, 5) == 5) ? '0 : 5'(1 << $urandom_range(0, N - 1));
        mole_position = pick;
      end else if ($urandom_range(0, 19) == 0) begin
        pulse = 1'b1;
      end
      if ($urandom_range(0, 199) == 0) enable = ~enable;
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 3))
          0:       buttons = '0;
          1:       buttons = mole_position;
          2:       buttons = 5'($urandom_range(0, 31));
          default: buttons = 5'(1 << $urandom_range(0, N - 1));
        endcase
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
